// File: rtl/ultrasonic_ranger_if.sv
// Pin-level and result bundle between the HC-SR04 ranger and its surroundings.
// master: the ranger itself; slave: the sensor/consumer side (bench, top-level glue).
interface ultrasonic_ranger_if;
  logic       echo;
  logic       trig;
  logic [8:0] distance_cm;
  logic       dist_valid;
  logic       timeout;
  logic       near;
  logic       busy;

  modport master (
    input  echo,
    output trig,
    output distance_cm,
    output dist_valid,
    output timeout,
    output near,
    output busy
  );

  modport slave (
    output echo,
    input  trig,
    input  distance_cm,
    input  dist_valid,
    input  timeout,
    input  near,
    input  busy
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranger: periodic trigger pulse, echo-width timing, conversion to whole centimetres.
// All outputs are registered; echo is brought into the clock domain by a 2-FF synchronizer.
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CYCLES      = 500,
  parameter int unsigned CM_CYCLES        = 2900,
  parameter int unsigned MAX_CM           = 400,
  parameter int unsigned ECHO_WAIT_CYCLES = 1500000,
  parameter int unsigned PERIOD_CYCLES    = 3000000,
  parameter int unsigned NEAR_CM          = 20
) (
  input logic                 clk,
  input logic                 rst_n,
  ultrasonic_ranger_if.master bus
);

  localparam int unsigned CW = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned SW = $clog2(CM_CYCLES + 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(ECHO_WAIT_CYCLES - 1);
  localparam logic [SW-1:0] SUB_LAST    = SW'(CM_CYCLES - 1);
  localparam logic [8:0]    MAX_CNT     = 9'(MAX_CM);
  localparam logic [8:0]    NEAR_CNT    = 9'(NEAR_CM);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t        state_r, state_next_s;
  logic [CW-1:0] period_r, cnt_r;
  logic [SW-1:0] sub_r;
  logic [8:0]    cm_r, cm_inc_s;
  logic          echo_meta_r, echo_sync_r, echo_prev_r, echo_rise_s, sub_wrap_s;
  logic [8:0]    result_cm_s;
  logic          result_timeout_s;
  logic          trig_r, busy_r, dist_valid_r, timeout_r, near_r;
  logic [8:0]    distance_r;
  logic          trig_s, busy_s, dist_valid_s, timeout_s, near_s;
  logic [8:0]    distance_s;

  assign echo_rise_s = echo_sync_r & ~echo_prev_r;
  assign sub_wrap_s  = (sub_r == SUB_LAST);
  assign cm_inc_s    = cm_r + 9'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta_r <= 1'b0;
      echo_sync_r <= 1'b0;
      echo_prev_r <= 1'b0;
    end else begin
      echo_meta_r <= bus.echo;
      echo_sync_r <= echo_meta_r;
      echo_prev_r <= echo_sync_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s     = state_r;
    result_cm_s      = cm_r;
    result_timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (period_r == PERIOD_LAST) state_next_s = TRIG;
        else                         state_next_s = IDLE;
      end
      TRIG: begin
        if (cnt_r == TRIG_LAST) state_next_s = WAIT_ECHO;
        else                    state_next_s = TRIG;
      end
      WAIT_ECHO: begin
        // Only a genuine low->high edge starts timing; a level already high is ignored.
        if (echo_rise_s) begin
          state_next_s = MEASURE;
        end else if (cnt_r == WAIT_LAST) begin
          state_next_s     = DONE;
          result_cm_s      = MAX_CNT;
          result_timeout_s = 1'b1;
        end else begin
          state_next_s = WAIT_ECHO;
        end
      end
      MEASURE: begin
        if (!echo_sync_r) begin
          state_next_s = DONE;
        end else if (sub_wrap_s && (cm_inc_s == MAX_CNT)) begin
          state_next_s     = DONE;
          result_cm_s      = MAX_CNT;
          result_timeout_s = 1'b1;
        end else begin
          state_next_s = MEASURE;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  always_comb begin
    trig_s       = (state_next_s == TRIG);
    busy_s       = (state_next_s == TRIG) || (state_next_s == WAIT_ECHO) ||
                   (state_next_s == MEASURE);
    dist_valid_s = (state_next_s == DONE);
    timeout_s    = 1'b0;
    distance_s   = distance_r;
    near_s       = near_r;
    if (state_next_s == DONE) begin
      timeout_s  = result_timeout_s;
      distance_s = result_cm_s;
      near_s     = (result_cm_s < NEAR_CNT);
    end else begin
      timeout_s  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_r       <= 1'b0;
      busy_r       <= 1'b0;
      dist_valid_r <= 1'b0;
      timeout_r    <= 1'b0;
      near_r       <= 1'b0;
      distance_r   <= MAX_CNT;
    end else begin
      trig_r       <= trig_s;
      busy_r       <= busy_s;
      dist_valid_r <= dist_valid_s;
      timeout_r    <= timeout_s;
      near_r       <= near_s;
      distance_r   <= distance_s;
    end
  end

  // The edge that detects the echo rise already counts as the first high cycle (sub starts at 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r <= PERIOD_LAST;
      cnt_r    <= {CW{1'b0}};
      sub_r    <= {SW{1'b0}};
      cm_r     <= 9'd0;
    end else begin
      if ((state_r == IDLE) && (state_next_s == TRIG)) period_r <= {CW{1'b0}};
      else if (period_r == PERIOD_LAST)                period_r <= {CW{1'b0}};
      else                                             period_r <= period_r + {{(CW-1){1'b0}}, 1'b1};
      if (state_next_s != state_r) cnt_r <= {CW{1'b0}};
      else                         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      if ((state_r == WAIT_ECHO) && (state_next_s == MEASURE)) begin
        sub_r <= SW'(1);
        cm_r  <= 9'd0;
      end else if (state_r == MEASURE) begin
        if (sub_wrap_s) begin
          sub_r <= {SW{1'b0}};
          cm_r  <= cm_inc_s;
        end else begin
          sub_r <= sub_r + {{(SW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign bus.trig        = trig_r;
  assign bus.busy        = busy_r;
  assign bus.dist_valid  = dist_valid_r;
  assign bus.timeout     = timeout_r;
  assign bus.near        = near_r;
  assign bus.distance_cm = distance_r;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with scaled-down timing parameters so a full
// trigger period fits in a few hundred cycles; expected values are hand-computed.
module tb_ultrasonic_ranger;
  localparam int TRIG  = 5;
  localparam int CM    = 10;
  localparam int MAXC  = 20;
  localparam int EW    = 300;
  localparam int PER   = 600;
  localparam int NEARC = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ultrasonic_ranger_if bus();

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .MAX_CM(MAXC),
    .ECHO_WAIT_CYCLES(EW), .PERIOD_CYCLES(PER), .NEAR_CM(NEARC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_trig(input logic want, output int at);
    bit seen = 1'b0;
    at = cyc;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (bus.trig === want) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check(want ? "trig_rise_seen" : "trig_fall_seen", {31'd0, seen}, 32'd1);
  endtask

  // One full trigger/echo cycle: echo goes high 2 cycles after trig fall for len cycles
  // (or stays high throughout when hold is set), then the strobed result is checked.
  task automatic do_meas(input string tag, input int len, input bit hold, input int exp_d,
                         input bit exp_to, input bit exp_near,
                         output int r, output int f, output int lat);
    bit got = 1'b0;
    int dv  = 0;
    wait_trig(1'b1, r);
    check({tag, "_busy_at_trig"}, {31'd0, bus.busy}, 32'd1);
    wait_trig(1'b0, f);
    for (int k = 0; k < 1000 && !got; k++) begin
      bus.echo = hold || ((k >= 2) && (k < 2 + len));
      @(negedge clk);
      if (bus.dist_valid === 1'b1) begin
        got = 1'b1;
        dv  = cyc;
      end
    end
    if (!hold) bus.echo = 1'b0;
    lat = dv - f;
    check({tag, "_dv_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_dist"}, {23'd0, bus.distance_cm}, exp_d);
    check({tag, "_timeout"}, {31'd0, bus.timeout}, {31'd0, exp_to});
    check({tag, "_near"}, {31'd0, bus.near}, {31'd0, exp_near});
    check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check({tag, "_strobe_width"}, {31'd0, bus.dist_valid}, 32'd0);
    check({tag, "_dist_hold"}, {23'd0, bus.distance_cm}, exp_d);
  endtask

  initial begin
    int rel, r1, f1, r2, r, f, lat;
    bus.echo = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trig",    {31'd0, bus.trig},       32'd0);
    check("rst_dist",    {23'd0, bus.distance_cm}, MAXC);
    check("rst_valid",   {31'd0, bus.dist_valid}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout},    32'd0);
    check("rst_near",    {31'd0, bus.near},       32'd0);
    check("rst_busy",    {31'd0, bus.busy},       32'd0);

    rst_n = 1'b1;
    rel   = cyc;
    do_meas("noecho", 0, 1'b0, MAXC, 1'b1, 1'b0, r1, f1, lat);
    check("first_trig_edge", r1 - rel, 32'd1);
    check("trig_width", f1 - r1, TRIG);
    check("echo_wait_lat", lat, EW);

    do_meas("cm5", 50, 1'b0, 5, 1'b0, 1'b0, r2, f, lat);
    check("trig_period", r2 - r1, PER);
    do_meas("cm4",   49,  1'b0, 4,    1'b0, 1'b1, r, f, lat);
    do_meas("cm0",   9,   1'b0, 0,    1'b0, 1'b1, r, f, lat);
    do_meas("cm1",   10,  1'b0, 1,    1'b0, 1'b1, r, f, lat);
    do_meas("cm19",  199, 1'b0, 19,   1'b0, 1'b0, r, f, lat);
    do_meas("cmmax", 200, 1'b0, MAXC, 1'b1, 1'b0, r, f, lat);
    do_meas("overrun", 250, 1'b0, MAXC, 1'b1, 1'b0, r, f, lat);

    do_meas("stuck1", 0, 1'b1, MAXC, 1'b1, 1'b0, r, f, lat);
    do_meas("stuck2", 0, 1'b1, MAXC, 1'b1, 1'b0, r, f, lat);
    check("stuck_wait_lat", lat, EW);
    bus.echo = 1'b0;

    do_meas("pre_rst", 49, 1'b0, 4, 1'b0, 1'b1, r, f, lat);
    wait_trig(1'b1, r);
    wait_trig(1'b0, f);
    bus.echo = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_trig",    {31'd0, bus.trig},       32'd0);
    check("midrst_busy",    {31'd0, bus.busy},       32'd0);
    check("midrst_dist",    {23'd0, bus.distance_cm}, MAXC);
    check("midrst_near",    {31'd0, bus.near},       32'd0);
    check("midrst_valid",   {31'd0, bus.dist_valid}, 32'd0);
    check("midrst_timeout", {31'd0, bus.timeout},    32'd0);
    repeat (4) @(negedge clk);
    bus.echo = 1'b0;
    rst_n    = 1'b1;
    rel      = cyc;
    do_meas("after_rst", 30, 1'b0, 3, 1'b0, 1'b1, r, f, lat);
    check("restart_edge", r - rel, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
